// File: rtl/ac97_pkg.sv
// ac97_pkg: AC97 register map, init length, scheduler states and command builders.
package ac97_pkg;
    localparam logic [6:0] REG_RESET    = 7'h00;
    localparam logic [6:0] REG_HP_VOL   = 7'h04;
    localparam logic [6:0] REG_BEEP_VOL = 7'h0A;
    localparam logic [6:0] REG_MIC_VOL  = 7'h0E;
    localparam logic [6:0] REG_PCM_VOL  = 7'h18;
    localparam logic [6:0] REG_REC_SEL  = 7'h1A;
    localparam logic [6:0] REG_REC_GAIN = 7'h1C;
    localparam logic [6:0] REG_GEN_PURP = 7'h20;
    localparam logic [7:0] READ_FLAG    = 8'h80;
    localparam int         INIT_LEN     = 7;
    localparam logic [23:0] IDLE_CMD    = {READ_FLAG | {1'b0, REG_RESET}, 16'h0000};

    typedef enum logic [1:0] {WAIT, INIT, RUN} state_t;

    function automatic logic [23:0] wr_cmd(input logic [6:0] addr, input logic [15:0] data);
        return {1'b0, addr, data};
    endfunction

    function automatic logic [23:0] hp_vol_cmd(input logic [4:0] att);
        return wr_cmd(REG_HP_VOL, {3'b000, att, 3'b000, att});
    endfunction

    function automatic logic [23:0] rec_sel_cmd(input logic [2:0] src);
        return wr_cmd(REG_REC_SEL, {5'b00000, src, 5'b00000, src});
    endfunction
endpackage

// File: rtl/ac97_init_rom.sv
// ac97_init_rom: codec bring-up command table, indexed by init step.
module ac97_init_rom
    import ac97_pkg::*;
(
    input  logic [2:0]  index,
    input  logic [4:0]  att,
    input  logic [2:0]  source,
    output logic [23:0] command
);
    always_comb begin
        case (index)
            3'd0:    command = hp_vol_cmd(att);
            3'd1:    command = wr_cmd(REG_PCM_VOL, 16'h0808);
            3'd2:    command = rec_sel_cmd(source);
            3'd3:    command = wr_cmd(REG_REC_GAIN, 16'h0F0F);
            3'd4:    command = wr_cmd(REG_MIC_VOL, 16'h8048);
            3'd5:    command = wr_cmd(REG_BEEP_VOL, 16'h0000);
            3'd6:    command = wr_cmd(REG_GEN_PURP, 16'h8000);
            default: command = IDLE_CMD;
        endcase
    end
endmodule

// File: rtl/ac97_cmd_sched.sv
// ac97_cmd_sched: issues one codec command per ready frame -- warm-up reads,
// init table, then host writes and volume/source tracking.
module ac97_cmd_sched
    import ac97_pkg::*;
#(
    parameter int INIT_WAIT = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        ready,
    input  logic [4:0]  volume,
    input  logic [2:0]  source,
    input  logic        host_req,
    input  logic [6:0]  host_addr,
    input  logic [15:0] host_data,
    output logic        host_ack,
    output logic [7:0]  command_address,
    output logic [15:0] command_data,
    output logic        command_valid,
    output logic        init_done
);
    state_t      state, state_n;
    logic        ready_q, load, ack_n, done_n;
    logic [15:0] cnt, cnt_n;
    logic [2:0]  idx, idx_n, src_sh, src_n;
    logic [4:0]  vol_sh, vol_n, att;
    logic [23:0] rom_cmd, cmd_n;

    assign load = ready & ~ready_q;
    assign att  = 5'd31 - volume;

    ac97_init_rom u_rom (.index(idx), .att(att), .source(source), .command(rom_cmd));

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        vol_n   = vol_sh;
        src_n   = src_sh;
        cmd_n   = {command_address, command_data};
        ack_n   = 1'b0;
        done_n  = init_done;
        if (load) begin
            case (state)
                WAIT: begin
                    cmd_n   = IDLE_CMD;
                    cnt_n   = cnt + 16'd1;
                    state_n = (int'(cnt) + 1 >= INIT_WAIT) ? INIT : WAIT;
                end
                INIT: begin
                    cmd_n = rom_cmd;
                    idx_n = idx + 3'd1;
                    vol_n = (idx == 3'd0) ? volume : vol_sh;
                    src_n = (idx == 3'd2) ? source : src_sh;
                    if (idx == 3'(INIT_LEN - 1)) begin
                        state_n = RUN;
                        done_n  = 1'b1;
                    end
                end
                default: begin
                    if (host_req) begin
                        cmd_n = wr_cmd(host_addr, host_data);
                        ack_n = 1'b1;
                    end else if (volume != vol_sh) begin
                        cmd_n = hp_vol_cmd(att);
                        vol_n = volume;
                    end else if (source != src_sh) begin
                        cmd_n = rec_sel_cmd(source);
                        src_n = source;
                    end else begin
                        cmd_n = IDLE_CMD;
                    end
                end
            endcase
        end
    end

    // ready_q resets high so a ready already high at release is not an edge
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state           <= WAIT;
            ready_q         <= 1'b1;
            cnt             <= '0;
            idx             <= '0;
            vol_sh          <= 5'd31;
            src_sh          <= 3'd0;
            command_address <= READ_FLAG;
            command_data    <= 16'h0000;
            command_valid   <= 1'b0;
            host_ack        <= 1'b0;
            init_done       <= 1'b0;
        end else begin
            state           <= state_n;
            ready_q         <= ready;
            cnt             <= cnt_n;
            idx             <= idx_n;
            vol_sh          <= vol_n;
            src_sh          <= src_n;
            command_address <= cmd_n[23:16];
            command_data    <= cmd_n[15:0];
            command_valid   <= 1'b1;
            host_ack        <= ack_n;
            init_done       <= done_n;
        end
    end
endmodule

// File: tb/tb_ac97_cmd_sched.sv
// tb_ac97_cmd_sched: randomized frame-level checks of ac97_cmd_sched against a
// load-count based reference model.
module tb_ac97_cmd_sched;
    localparam int INIT_WAIT = 2;

    logic        clock = 1'b0;
    logic        reset_n, ready, host_req;
    logic [4:0]  volume;
    logic [2:0]  source;
    logic [6:0]  host_addr;
    logic [15:0] host_data;
    logic        host_ack, command_valid, init_done;
    logic [7:0]  command_address;
    logic [15:0] command_data;

    int tests = 0;
    int fails = 0;

    int         m_loads;
    logic [4:0] m_vol;
    logic [2:0] m_src;
    logic       m_done;

    ac97_cmd_sched #(.INIT_WAIT(INIT_WAIT)) dut (
        .clock(clock), .reset_n(reset_n), .ready(ready), .volume(volume), .source(source),
        .host_req(host_req), .host_addr(host_addr), .host_data(host_data), .host_ack(host_ack),
        .command_address(command_address), .command_data(command_data),
        .command_valid(command_valid), .init_done(init_done)
    );

    always #5 clock = ~clock;

    // Expected command for the n-th load since reset, from the published table and priorities
    task automatic model_step(output logic [23:0] e, output logic ea);
        int k;
        logic [4:0] a;
        a  = 5'd31 - volume;
        ea = 1'b0;
        k  = m_loads - INIT_WAIT;
        if (m_loads < INIT_WAIT) e = 24'h800000;
        else if (k < 7) begin
            case (k)
                0: begin e = {8'h04, 3'b0, a, 3'b0, a}; m_vol = volume; end
                1: e = 24'h180808;
                2: begin e = {8'h1A, 5'b0, source, 5'b0, source}; m_src = source; end
                3: e = 24'h1C0F0F;
                4: e = 24'h0E8048;
                5: e = 24'h0A0000;
                default: begin e = 24'h208000; m_done = 1'b1; end
            endcase
        end else if (host_req) begin
            e  = {1'b0, host_addr, host_data};
            ea = 1'b1;
        end else if (volume != m_vol) begin
            e = {8'h04, 3'b0, a, 3'b0, a};
            m_vol = volume;
        end else if (source != m_src) begin
            e = {8'h1A, 5'b0, source, 5'b0, source};
            m_src = source;
        end else e = 24'h800000;
        m_loads++;
    endtask

    // One ready pulse (one cycle high, one low); called at a negedge
    task automatic frame(output logic [23:0] c, output logic a1, output logic a2, output logic d);
        ready = 1'b1;
        @(negedge clock);
        c  = {command_address, command_data};
        a1 = host_ack;
        d  = init_done;
        ready = 1'b0;
        @(negedge clock);
        a2 = host_ack;
    endtask

    task automatic do_reset(input logic rdy);
        reset_n = 1'b0;
        ready   = rdy;
        m_loads = 0;
        m_vol   = 5'd31;
        m_src   = 3'd0;
        m_done  = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        ready = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_reset;
        reset_n = 1'b0; ready = 1'b1;
        repeat (2) @(negedge clock);
        tests += 5;
        if (command_address !== 8'h80) begin fails++; $display("FAIL reset_addr: got %h expected 80", command_address); end
        if (command_data !== 16'h0) begin fails++; $display("FAIL reset_data: got %h expected 0000", command_data); end
        if (command_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", command_valid); end
        if (host_ack !== 1'b0) begin fails++; $display("FAIL reset_ack: got %b expected 0", host_ack); end
        if (init_done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", init_done); end
        do_reset(1'b1);
        tests += 2;
        if (command_valid !== 1'b1) begin fails++; $display("FAIL wait_valid: got %b expected 1", command_valid); end
        if ({command_address, command_data} !== 24'h800000) begin fails++; $display("FAIL wait_cmd: got %h expected 800000", {command_address, command_data}); end
    endtask

    task automatic test_init_seq;
        logic [23:0] e, c;
        logic ea, a1, a2, d;
        volume = 5'd31; source = 3'd0;
        for (int i = 0; i < 10; i++) begin
            model_step(e, ea);
            frame(c, a1, a2, d);
            tests += 3;
            if (c !== e) begin fails++; $display("FAIL init_cmd[%0d]: got %h expected %h", i, c, e); end
            if (a1 !== 1'b0 || a2 !== 1'b0) begin fails++; $display("FAIL init_ack[%0d]: got %b%b expected 00", i, a1, a2); end
            if (d !== m_done) begin fails++; $display("FAIL init_done[%0d]: got %b expected %b", i, d, m_done); end
        end
    endtask

    task automatic test_volume;
        logic [23:0] e, c;
        logic ea, a1, a2, d;
        volume = 5'd10;
        for (int i = 0; i < 3; i++) begin
            model_step(e, ea);
            frame(c, a1, a2, d);
            tests++;
            if (c !== e || (i == 0 && c !== 24'h041515)) begin fails++; $display("FAIL volume[%0d]: got %h expected %h", i, c, e); end
        end
    endtask

    task automatic test_vol_src;
        logic [23:0] e, c;
        logic ea, a1, a2, d;
        volume = 5'(volume + 5'($urandom_range(1, 31)));
        source = 3'd3;
        for (int i = 0; i < 3; i++) begin
            model_step(e, ea);
            frame(c, a1, a2, d);
            tests++;
            if (c !== e || (i == 1 && c !== 24'h1A0303)) begin fails++; $display("FAIL vol_src[%0d]: got %h expected %h", i, c, e); end
        end
    endtask

    task automatic test_random;
        logic [23:0] e, c;
        logic ea, a1, a2, d;
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 2)) begin
                if ($urandom_range(0, 2) == 0) volume = 5'($urandom);
                if ($urandom_range(0, 3) == 0) source = 3'($urandom);
                @(negedge clock);
            end
            model_step(e, ea);
            frame(c, a1, a2, d);
            tests++;
            if (c !== e) begin fails++; $display("FAIL random[%0d]: got %h expected %h", i, c, e); end
        end
    endtask

    task automatic test_ready_hold;
        logic [23:0] e, c;
        logic ea, a1, a2, d;
        volume = 5'(volume + 5'($urandom_range(1, 31)));
        model_step(e, ea);
        ready = 1'b1;
        @(negedge clock);
        tests++;
        if ({command_address, command_data} !== e) begin fails++; $display("FAIL hold_first: got %h expected %h", {command_address, command_data}, e); end
        volume = 5'(volume + 5'($urandom_range(1, 31)));
        repeat (4) @(negedge clock);
        tests++;
        if ({command_address, command_data} !== e) begin fails++; $display("FAIL hold_single: got %h expected %h", {command_address, command_data}, e); end
        ready = 1'b0;
        @(negedge clock);
        model_step(e, ea);
        frame(c, a1, a2, d);
        tests++;
        if (c !== e) begin fails++; $display("FAIL hold_next: got %h expected %h", c, e); end
    endtask

    task automatic test_host_init;
        logic [23:0] e, c;
        logic ea, a1, a2, d;
        do_reset(1'b0);
        host_req = 1'b1; host_addr = 7'h02; host_data = 16'h8000;
        for (int i = 0; i < 9; i++) begin
            if (i == 4) volume = 5'(volume + 5'($urandom_range(1, 31)));
            model_step(e, ea);
            frame(c, a1, a2, d);
            tests++;
            if (c !== e || a1 !== 1'b0 || a2 !== 1'b0) begin fails++; $display("FAIL host_init[%0d]: got %h ack %b%b expected %h ack 00", i, c, a1, a2, e); end
        end
        model_step(e, ea);
        frame(c, a1, a2, d);
        tests += 2;
        if (c !== e || c !== 24'h028000) begin fails++; $display("FAIL host_first_run: got %h expected %h", c, e); end
        if (a1 !== 1'b1 || a2 !== 1'b0) begin fails++; $display("FAIL host_ack_pulse: got %b%b expected 10", a1, a2); end
        host_req = 1'b0;
        model_step(e, ea);
        frame(c, a1, a2, d);
        tests++;
        if (c !== e || a1 !== 1'b0) begin fails++; $display("FAIL host_then_vol: got %h ack %b expected %h ack 0", c, a1, e); end
    endtask

    task automatic test_host_drop;
        logic [23:0] e, c;
        logic ea, a1, a2, d;
        host_req = 1'b1; host_addr = 7'($urandom); host_data = 16'($urandom);
        @(negedge clock);
        host_req = 1'b0;
        model_step(e, ea);
        frame(c, a1, a2, d);
        tests++;
        if (c !== e || a1 !== 1'b0 || a2 !== 1'b0) begin fails++; $display("FAIL host_drop: got %h ack %b%b expected %h ack 00", c, a1, a2, e); end
    endtask

    task automatic test_reset_mid;
        logic [23:0] e, c;
        logic ea, a1, a2, d;
        do_reset(1'b0);
        for (int i = 0; i < INIT_WAIT + 3; i++) begin
            model_step(e, ea);
            frame(c, a1, a2, d);
        end
        #2 reset_n = 1'b0;
        #1;
        tests++;
        if ({command_address, command_data} !== 24'h800000 || command_valid !== 1'b0 || init_done !== 1'b0 || host_ack !== 1'b0)
            begin fails++; $display("FAIL mid_reset_outputs: got %h v%b d%b a%b expected 800000 v0 d0 a0", {command_address, command_data}, command_valid, init_done, host_ack); end
        @(negedge clock);
        do_reset(1'b0);
        for (int i = 0; i < 10; i++) begin
            model_step(e, ea);
            frame(c, a1, a2, d);
            tests++;
            if (c !== e || d !== m_done) begin fails++; $display("FAIL restart[%0d]: got %h done %b expected %h done %b", i, c, d, e, m_done); end
        end
    endtask

    initial begin
        ready = 1'b0; reset_n = 1'b0; volume = 5'd31; source = 3'd0;
        host_req = 1'b0; host_addr = 7'h0; host_data = 16'h0;
        test_reset();
        test_init_seq();
        test_volume();
        test_vol_src();
        test_random();
        test_ready_hold();
        test_host_drop();
        test_host_init();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ac97_cmd_sched.md
AC97_CMD_SCHED -- requirements
Module: ac97_cmd_sched

Interface
- REQ-001 SHALL have parameter INIT_WAIT, default 2: number of ready frames spent issuing register-0 reads before the init sequence starts.
- REQ-002 SHALL have port clock, input, 1 bit: single system clock; all state advances on its rising edge.
- REQ-003 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
- REQ-004 SHALL have port ready, input, 1 bit: codec frame strobe; a rising edge means the current command slot has been consumed.
- REQ-005 SHALL have port volume, input, 5 bits: headphone volume, where 31 is loudest.
- REQ-006 SHALL have port source, input, 3 bits: record source select.
- REQ-007 SHALL have ports host_req (input, 1 bit), host_addr (input, 7 bits) and host_data (input, 16 bits): generic register-write request.
- REQ-008 SHALL have port host_ack, output, 1 bit: one-cycle pulse when the host write is loaded.
- REQ-009 SHALL have port command_address, output, 8 bits: bit 7 set means a read.
- REQ-010 SHALL have port command_data, output, 16 bits, and port command_valid, output, 1 bit.
- REQ-011 SHALL have port init_done, output, 1 bit: high once the init sequence is complete.

Function
- REQ-012 SHALL detect the ready rising edge using a registered previous value; a ready held high for several cycles counts as one event.
- REQ-013 SHALL register all outputs; command outputs change only on the clock edge after a detected ready edge ("load").
- REQ-014 SHALL implement states WAIT -> INIT -> RUN, with no path back except reset.
- REQ-015 WAIT: command = 80_0000 with command_valid=1 from the first clock after reset release; after INIT_WAIT loads, go to INIT.
- REQ-016 INIT: load 7 entries in order, one per ready edge, then set init_done=1 and go to RUN:
  - 04_{000,att,000,att}
  - 18_0808
  - 1A_{00000,src,00000,src}
  - 1C_0F0F
  - 0E_8048
  - 0A_0000
  - 20_8000
- REQ-017 Attenuation: att = 31 - volume, computed as 5-bit unsigned (volume=31 gives 0000; volume=0 gives 1F1F).
- REQ-018 The volume and source entries SHALL use the live input values at load time and copy them into shadow registers vol_sh and src_sh.
- REQ-019 RUN: at each load, select by fixed priority:
  - pending host request
  - volume != vol_sh (write reg 04)
  - source != src_sh (write reg 1A)
  - otherwise idle read 80_0000
- REQ-020 Host write SHALL load {1'b0, host_addr, host_data}; host_ack pulses high for exactly the load cycle.
- REQ-021 The host SHALL hold req, addr and data stable until ack; host_req deasserted before a load is dropped without ack.
- REQ-022 host_req during WAIT or INIT SHALL be held pending (not acked) and served at the first RUN load.
- REQ-023 A volume or source change after a load SHALL be written at a later load; several changes between loads produce one write carrying the latest value.
- REQ-024 A volume change and a source change at the same load SHALL write volume first and source at the next load.
- REQ-025 A ready edge coinciding with reset deassertion SHALL be ignored.

Reset
- REQ-026 While reset_n=0 the outputs SHALL be: command_address=80, command_data=0000, command_valid=0, host_ack=0, init_done=0, state=WAIT.
- REQ-027 In reset, the frame count and INIT index SHALL be 0, vol_sh=31 and src_sh=0.
- REQ-028 Assertion of reset mid-sequence SHALL abort immediately; after release the full WAIT/INIT sequence SHALL restart.

Structure
- REQ-029 Shared package ac97_pkg SHALL hold:
  - register address constants (00, 04, 0A, 0E, 18, 1A, 1C, 20)
  - READ_FLAG=80
  - INIT_LEN=7
  - state enum {WAIT, INIT, RUN}
- REQ-030 Sub-module ac97_init_rom SHALL be combinational: (index, att, source) -> 24-bit command.

Verification
- REQ-031 Reset, INIT_WAIT=2, volume=31, source=0, 10 ready edges: 2 reads of 80_0000, then 04_0000, 18_0808, 1A_0000, 1C_0F0F, 0E_8048, 0A_0000, 20_8000, after which init_done=1.
- REQ-032 In RUN, change volume 31->10: next load is 04_1515; following loads are 80_0000.
- REQ-033 In RUN, change volume and source=3 in the same cycle: loads are 04_xxxx then 1A_0303 on consecutive edges.
- REQ-034 Assert host_req (addr 02, data 8000) during INIT: no ack during INIT; first RUN load is 02_8000 with a one-cycle ack, and it takes priority over a pending volume change.
- REQ-035 Hold ready high for 5 cycles: exactly one load occurs.
- REQ-036 Pulse reset_n low at INIT index 3: outputs return to reset values and the sequence restarts with 2 WAIT reads.
